// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT coefficient multiplier: size encodings, magnitude
// select codes and the folded-angle to select-code map.
package idct_pkg;

    localparam logic [1:0] SZ4  = 2'd0;
    localparam logic [1:0] SZ8  = 2'd1;
    localparam logic [1:0] SZ16 = 2'd2;

    localparam int unsigned NUM_MULT = 15;

    // Code k (k >= 1) selects multiple k-1 of the shift-add bank.
    typedef enum logic [3:0] {
        SelZero, Sel9, Sel18, Sel25, Sel36, Sel43, Sel50, Sel57,
        Sel64, Sel70, Sel75, Sel80, Sel83, Sel87, Sel89, Sel90
    } mag_sel_e;

    function automatic mag_sel_e mag_to_sel(input logic [4:0] m);
        mag_sel_e sel;
        case (m)
            5'd0:    sel = Sel64;
            5'd1:    sel = Sel90;
            5'd2:    sel = Sel89;
            5'd3:    sel = Sel87;
            5'd4:    sel = Sel83;
            5'd5:    sel = Sel80;
            5'd6:    sel = Sel75;
            5'd7:    sel = Sel70;
            5'd8:    sel = Sel64;
            5'd9:    sel = Sel57;
            5'd10:   sel = Sel50;
            5'd11:   sel = Sel43;
            5'd12:   sel = Sel36;
            5'd13:   sel = Sel25;
            5'd14:   sel = Sel18;
            5'd15:   sel = Sel9;
            default: sel = SelZero; // angle 16 is cos(pi/2)
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/idct_coef_mul_pipe_if.sv
// Handshake and data bundle for the coefficient multiplier: sample input side and
// lane product output side.
interface idct_coef_mul_pipe_if #(
    parameter int unsigned WIDTH_X = 16,
    parameter int unsigned WIDTH_Y = 23,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned LANES   = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH_X-1:0]   x_in;
    logic [1:0]                  size;
    logic [3:0]                  row;
    logic [TAG_W-1:0]            tag_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*WIDTH_Y-1:0]    y_out;
    logic [TAG_W-1:0]            tag_out;

    modport master (
        output in_valid, x_in, size, row, tag_in, out_ready,
        input  in_ready, out_valid, y_out, tag_out
    );

    modport slave (
        input  in_valid, x_in, size, row, tag_in, out_ready,
        output in_ready, out_valid, y_out, tag_out
    );

endinterface

// File: rtl/idct_shift_add_bank.sv
// Combinational bank producing the 15 distinct HEVC coefficient multiples of x
// using shifts and at most three adders per multiple.
module idct_shift_add_bank
    import idct_pkg::*;
#(
    parameter int unsigned WIDTH_X = 16,
    parameter int unsigned WIDTH_Y = 23
) (
    input  logic signed [WIDTH_X-1:0]               x,
    output logic        [NUM_MULT-1:0][WIDTH_Y-1:0] mult
);

    logic signed [WIDTH_Y-1:0] x1, x2, x4, x8, x16, x32, x64;

    always_comb begin
        x1  = {{(WIDTH_Y-WIDTH_X){x[WIDTH_X-1]}}, x};
        x2  = x1 <<< 1;
        x4  = x1 <<< 2;
        x8  = x1 <<< 3;
        x16 = x1 <<< 4;
        x32 = x1 <<< 5;
        x64 = x1 <<< 6;
    end

    always_comb begin
        mult[0]  = x8 + x1;                  // 9
        mult[1]  = x16 + x2;                 // 18
        mult[2]  = x16 + x8 + x1;            // 25
        mult[3]  = x32 + x4;                 // 36
        mult[4]  = x32 + x8 + x2 + x1;       // 43
        mult[5]  = x32 + x16 + x2;           // 50
        mult[6]  = x64 - x8 + x1;            // 57
        mult[7]  = x64;                      // 64
        mult[8]  = x64 + x4 + x2;            // 70
        mult[9]  = x64 + x8 + x2 + x1;       // 75
        mult[10] = x64 + x16;                // 80
        mult[11] = x64 + x16 + x2 + x1;      // 83
        mult[12] = x64 + x16 + x8 - x1;      // 87
        mult[13] = x64 + x16 + x8 + x1;      // 89
        mult[14] = x64 + x16 + x8 + x2;      // 90
    end

endmodule

// File: rtl/idct_coef_mul_pipe.sv
// Two-stage pipelined constant-multiplier bank for 4/8/16-point IDCT rows with
// valid/ready flow control and a forwarded sideband tag.
module idct_coef_mul_pipe
    import idct_pkg::*;
#(
    parameter int unsigned WIDTH_X = 16,
    parameter int unsigned WIDTH_Y = 23,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned LANES   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    idct_coef_mul_pipe_if.slave bus
);

    logic ld1, ld2, accept;
    logic v1, v2;

    logic [NUM_MULT-1:0][WIDTH_Y-1:0] mult_d, mult_q;
    mag_sel_e                         sel_d [LANES];
    mag_sel_e                         sel_q [LANES];
    logic [TAG_W-1:0]                 tag1_q, tag2_q;
    logic [LANES-1:0][WIDTH_Y-1:0]    y_d, y_q;

    assign ld2    = !v2 || bus.out_ready;
    assign ld1    = !v1 || ld2;
    assign accept = bus.in_valid && ld1;

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v2;
    assign bus.y_out     = y_q;
    assign bus.tag_out   = tag2_q;

    idct_shift_add_bank #(
        .WIDTH_X (WIDTH_X),
        .WIDTH_Y (WIDTH_Y)
    ) u_bank (
        .x    (bus.x_in),
        .mult (mult_d)
    );

    // Row scaled onto the 16-point matrix; angle advances by 2*r16 per lane.
    logic [3:0]  r16;
    int unsigned n_act;
    logic [6:0]  acc;
    logic [6:0]  m;

    always_comb begin
        r16   = bus.row;
        n_act = 8;
        case (bus.size)
            SZ4: begin
                r16   = {bus.row[1:0], 2'b00};
                n_act = 2;
            end
            SZ8: begin
                r16   = {bus.row[2:0], 1'b0};
                n_act = 4;
            end
            default: begin
                r16   = bus.row;
                n_act = 8;
            end
        endcase

        acc = {3'b000, r16};
        m   = '0;
        for (int j = 0; j < LANES; j++) begin
            m = {1'b0, acc[5:0]};
            if (m > 7'd32) m = 7'd64 - m;
            if (m > 7'd16) m = 7'd32 - m;
            sel_d[j] = (j < int'(n_act)) ? mag_to_sel(m[4:0]) : SelZero;
            acc      = acc + {2'b00, r16, 1'b0};
        end
    end

    logic [3:0] idx [LANES];

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            idx[j] = sel_q[j] - 4'd1;
            y_d[j] = (sel_q[j] == SelZero) ? '0 : mult_q[idx[j]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            mult_q <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            y_q    <= '0;
            for (int j = 0; j < LANES; j++) sel_q[j] <= SelZero;
        end else begin
            if (ld1) begin
                v1 <= accept;
                if (accept) begin
                    mult_q <= mult_d;
                    tag1_q <= bus.tag_in;
                    for (int j = 0; j < LANES; j++) sel_q[j] <= sel_d[j];
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    y_q    <= y_d;
                    tag2_q <= tag1_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_idct_coef_mul_pipe.sv
// Directed self-checking bench for idct_coef_mul_pipe: single samples, streaming,
// back-pressure and mid-stream reset.
module tb_idct_coef_mul_pipe;

    localparam int WX = 16;
    localparam int WY = 23;
    localparam int TW = 2;
    localparam int NL = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idct_coef_mul_pipe_if #(.WIDTH_X(WX), .WIDTH_Y(WY), .TAG_W(TW), .LANES(NL)) bus ();

    idct_coef_mul_pipe #(
        .WIDTH_X (WX),
        .WIDTH_Y (WY),
        .TAG_W   (TW),
        .LANES   (NL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    longint e1 [8] = '{8900, 7500, 5000, 1800, 0, 0, 0, 0};
    longint e2 [8] = '{-270, -261, -240, -210, -171, -129, -75, -27};
    longint e3 [8] = '{830, 360, 0, 0, 0, 0, 0, 0};
    longint e4 [8] = '{-2097152, -2097152, 0, 0, 0, 0, 0, 0};
    longint e5 [8] = '{87000, 57000, 9000, 43000, 80000, 90000, 70000, 25000};

    int bp_x [6] = '{5, -7, 123, -1000, 32767, -1};
    int bp_r [6] = '{0, 1, 2, 3, 4, 5};
    int bp_t [6] = '{1, 2, 3, 0, 1, 2};
    int send;
    int rcv;
    bit seen90;

    task automatic check(input string name, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic longint lane(input int j);
        logic signed [WY-1:0] t;
        t = bus.y_out[j*WY +: WY];
        return longint'(t);
    endfunction

    function automatic longint mag_of(input int m);
        case (m)
            0: return 64;   1: return 90;   2: return 89;   3: return 87;
            4: return 83;   5: return 80;   6: return 75;   7: return 70;
            8: return 64;   9: return 57;  10: return 50;  11: return 43;
           12: return 36;  13: return 25;  14: return 18;  15: return 9;
            default: return 0;
        endcase
    endfunction

    function automatic longint exp_lane(input int sz, input int r, input int j, input longint x);
        int n, r16, m;
        n = (sz == 0) ? 4 : (sz == 1) ? 8 : 16;
        if (j >= n / 2) return 0;
        r16 = ((r % n) * 16) / n;
        m = ((2 * j + 1) * r16) % 64;
        if (m > 32) m = 64 - m;
        if (m > 16) m = 32 - m;
        return x * mag_of(m);
    endfunction

    task automatic drive(input bit v, input int sz, input int r, input longint x, input int tg);
        bus.in_valid = v;
        bus.size     = 2'(sz);
        bus.row      = 4'(r);
        bus.x_in     = 16'(x);
        bus.tag_in   = 2'(tg);
    endtask

    task automatic check_model(input string name, input int sz, input int r, input longint x,
                               input int tg);
        for (int j = 0; j < NL; j++)
            check($sformatf("%s_r%0d_y%0d", name, r, j), lane(j), exp_lane(sz, r, j, x));
        check($sformatf("%s_r%0d_tag", name, r), longint'(bus.tag_out), longint'(tg));
    endtask

    // Sample presented before edge A, accepted at A, visible after the next edge.
    task automatic send_one(input string name, input int sz, input int r, input longint x,
                            input int tg, input longint e [8]);
        @(negedge clk);
        check({name, "_in_ready"}, longint'(bus.in_ready), 1);
        drive(1'b1, sz, r, x, tg);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 0, 0, 0, 0);
        check({name, "_lat1"}, longint'(bus.out_valid), 0);
        @(negedge clk);
        check({name, "_valid"}, longint'(bus.out_valid), 1);
        for (int j = 0; j < NL; j++)
            check($sformatf("%s_y%0d", name, j), lane(j), e[j]);
        check({name, "_tag"}, longint'(bus.tag_out), longint'(tg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_y_zero", longint'(bus.y_out == '0), 1);
        check("rst_tag", longint'(bus.tag_out), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);

        send_one("sz8_r1", 1, 1, 100, 1, e1);
        send_one("sz16_r1", 2, 1, -3, 2, e2);
        send_one("sz4_r1", 0, 1, 10, 3, e3);
        send_one("sz4_r0", 0, 0, -32768, 0, e4);

        // Full-rate stream over every 16-point row.
        seen90 = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check("stream_valid", longint'(bus.out_valid), 1);
                check_model("stream", 2, c - 2, -32768, (c - 2) % 4);
                for (int j = 0; j < NL; j++) if (lane(j) == -2949120) seen90 = 1'b1;
            end
            if (c < 16) begin
                check("stream_in_ready", longint'(bus.in_ready), 1);
                drive(1'b1, 2, c, -32768, c % 4);
            end else begin
                drive(1'b0, 0, 0, 0, 0);
            end
        end
        @(negedge clk);
        check("stream_drained", longint'(bus.out_valid), 0);
        check("stream_seen90", longint'(seen90), 1);

        // Back-pressure: fill both stages, stall, then release.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 1, bp_r[0], bp_x[0], bp_t[0]);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_one", longint'(bus.in_ready), 1);
        drive(1'b1, 1, bp_r[1], bp_x[1], bp_t[1]);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_drop", longint'(bus.in_ready), 0);
        check("bp_full_valid", longint'(bus.out_valid), 1);
        drive(1'b1, 1, bp_r[2], bp_x[2], bp_t[2]);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_stall_ready", longint'(bus.in_ready), 0);
            check("bp_stall_valid", longint'(bus.out_valid), 1);
            check_model("bp_hold", 1, bp_r[0], bp_x[0], bp_t[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", longint'(bus.in_ready), 1);
        send = 2;
        rcv  = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (bus.in_valid) send++;
            @(negedge clk);
            if (bus.out_valid) begin
                if (rcv < 6) check_model("bp_order", 1, bp_r[rcv], bp_x[rcv], bp_t[rcv]);
                rcv++;
            end
            if (send < 6) drive(1'b1, 1, bp_r[send], bp_x[send], bp_t[send]);
            else drive(1'b0, 0, 0, 0, 0);
        end
        check("bp_count", longint'(rcv), 6);

        // Reset with both stages occupied.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 2, 5, 1234, 3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2, 6, -555, 2);
        @(posedge clk);
        @(negedge clk);
        check("mid_full_valid", longint'(bus.out_valid), 1);
        check("mid_full_ready", longint'(bus.in_ready), 0);
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", longint'(bus.out_valid), 0);
        check("mid_rst_y_zero", longint'(bus.y_out == '0), 1);
        check("mid_rst_tag", longint'(bus.tag_out), 0);
        check("mid_rst_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_one("post_rst", 2, 3, 1000, 1, e5);
        @(negedge clk);
        check("post_rst_drained", longint'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
